// File: rtl/stopwatch_core.sv
// stopwatch_core: divides the system clock to a 10 ms tick and keeps an
// mm:ss.cc packed-BCD stopwatch with start/pause/clear control, a limit
// flag, and a one-cycle active-low lap-store strobe for the lap registers.
module stopwatch_core #(
  parameter int DIV  = 500000,
  parameter int WRAP = 0
) (
  input  logic       CP,
  input  logic       RST,
  input  logic       SS,
  input  logic       CLR,
  input  logic       LAP,
  output logic [7:0] min,
  output logic [7:0] s,
  output logic [7:0] ms,
  output logic       LAP_N,
  output logic       RUNNING,
  output logic       OVF
);

  localparam int            PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FULL} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    cs_q, cs_d;
  logic          lap_n_q, lap_n_d;
  logic          ovf_q, ovf_d;
  logic          running_q, running_d;

  logic lap_ok;
  logic tick;
  logic at_limit;

  // One BCD byte step: wraps to 00 at 'top', otherwise carries low digit 9 into the high digit.
  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // A lap is only honoured while the watch holds a meaningful running/paused value;
  // an accepted lap holds off a due tick so the strobe cycle shows the sampled value.
  assign lap_ok   = LAP && !CLR && ((state_q == RUN) || (state_q == PAUSE));
  assign tick     = (state_q == RUN) && (presc_q == PRESC_MAX) && !lap_ok;
  assign at_limit = (min_q == 8'h59) && (sec_q == 8'h59) && (cs_q == 8'h99);

  // Next-state logic: control FSM, prescaler, BCD cascade, lap strobe and limit flag.
  // NOTE: every _d signal gets its default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    min_d   = min_q;
    sec_d   = sec_q;
    cs_d    = cs_q;
    lap_n_d = 1'b1;
    ovf_d   = (state_q == FULL);

    if (CLR) begin
      state_d = IDLE;
      presc_d = '0;
      min_d   = 8'h00;
      sec_d   = 8'h00;
      cs_d    = 8'h00;
      ovf_d   = 1'b0;
    end else begin
      lap_n_d = !lap_ok;

      // Prescaler only advances in RUN; it parks at its last count during a lap stall.
      if (state_q == RUN) begin
        if (tick) begin
          presc_d = '0;
        end else if (presc_q != PRESC_MAX) begin
          presc_d = presc_q + PW'(1);
        end
      end

      if (SS) begin
        case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = state_q;
        endcase
      end

      // The limit tick outranks a simultaneous SS: saturation wins over pause.
      if (tick) begin
        if (at_limit && (WRAP == 0)) begin
          state_d = FULL;
          ovf_d   = 1'b1;
        end else begin
          cs_d = bcd_next(cs_q, 8'h99);
          if (cs_q == 8'h99) begin
            sec_d = bcd_next(sec_q, 8'h59);
            if (sec_q == 8'h59) begin
              min_d = bcd_next(min_q, 8'h59);
            end
          end
          if (at_limit) ovf_d = 1'b1;
        end
      end
    end

    running_d = (state_d == RUN);
  end

  // State and output registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CP) begin
    if (!RST) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      cs_q      <= 8'h00;
      lap_n_q   <= 1'b1;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      cs_q      <= cs_d;
      lap_n_q   <= lap_n_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
    end
  end

  assign min     = min_q;
  assign s       = sec_q;
  assign ms      = cs_q;
  assign LAP_N   = lap_n_q;
  assign RUNNING = running_q;
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: drives a saturating (WRAP=0) and a wrapping (WRAP=1)
// stopwatch with identical stimulus and compares both against a model that
// keeps elapsed time as a plain centisecond count.
`timescale 1ns/1ps
module tb_stopwatch_core;

  localparam int DIV   = 4;
  localparam int LIMIT = 359999;  // 59:59.99 in centiseconds

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_FULL} mstate_e;

  logic clk = 1'b0;
  logic rst, ss, clr, lap;
  logic [7:0] min0, s0, ms0, min1, s1, ms1;
  logic lapn0, run0, ovf0, lapn1, run1, ovf1;

  int tests = 0;
  int fails = 0;

  // Reference model, one slot per instance (0: saturating, 1: wrapping).
  int      m_t[2];     // elapsed centiseconds
  int      m_acc[2];   // run cycles accumulated toward the next 10 ms step
  mstate_e m_st[2];
  bit      m_lapn[2];
  bit      m_run[2];
  bit      m_ovf[2];

  logic [7:0] pre_min, pre_sec, pre_cs;

  always #5 clk = ~clk;

  stopwatch_core #(.DIV(DIV), .WRAP(0)) u_dut0 (
    .CP(clk), .RST(rst), .SS(ss), .CLR(clr), .LAP(lap),
    .min(min0), .s(s0), .ms(ms0), .LAP_N(lapn0), .RUNNING(run0), .OVF(ovf0)
  );

  stopwatch_core #(.DIV(DIV), .WRAP(1)) u_dut1 (
    .CP(clk), .RST(rst), .SS(ss), .CLR(clr), .LAP(lap),
    .min(min1), .s(s1), .ms(ms1), .LAP_N(lapn1), .RUNNING(run1), .OVF(ovf1)
  );

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [26:0] exp_vec(input int i);
    int t;
    t = m_t[i];
    return {bcd2(t / 6000), bcd2((t / 100) % 60), bcd2(t % 100), m_lapn[i], m_run[i], m_ovf[i]};
  endfunction

  function automatic logic [26:0] got_vec(input int i);
    if (i == 0) return {min0, s0, ms0, lapn0, run0, ovf0};
    return {min1, s1, ms1, lapn1, run1, ovf1};
  endfunction

  function automatic bit digits_ok(input int i);
    logic [23:0] v;
    v = got_vec(i)[26:3];
    for (int k = 0; k < 6; k++) if (v[k*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // One clock edge of the specification's behaviour, written on elapsed time.
  function automatic void model_step(input int i, input bit r, input bit c, input bit s_in, input bit l);
    bit      lap_ok;
    bit      tick;
    mstate_e nxt;
    if (!r || c) begin
      m_t[i] = 0; m_acc[i] = 0; m_st[i] = M_IDLE;
      m_lapn[i] = 1'b1; m_run[i] = 1'b0; m_ovf[i] = 1'b0;
      return;
    end
    lap_ok    = l && (m_st[i] == M_RUN || m_st[i] == M_PAUSE);
    m_lapn[i] = !lap_ok;
    m_ovf[i]  = (m_st[i] == M_FULL);
    tick      = 1'b0;
    nxt       = m_st[i];
    if (m_st[i] == M_RUN) begin
      if (m_acc[i] < DIV - 1) m_acc[i]++;
      else if (!lap_ok) begin tick = 1'b1; m_acc[i] = 0; end
    end
    if (s_in) begin
      if (m_st[i] == M_IDLE || m_st[i] == M_PAUSE) nxt = M_RUN;
      else if (m_st[i] == M_RUN) nxt = M_PAUSE;
    end
    if (tick) begin
      if (m_t[i] < LIMIT) m_t[i]++;
      else begin
        m_ovf[i] = 1'b1;
        if (i == 1) m_t[i] = 0;
        else nxt = M_FULL;
      end
    end
    m_st[i]  = nxt;
    m_run[i] = (nxt == M_RUN);
  endfunction

  task automatic cycle(input bit s_in, input bit c, input bit l, input bit r);
    ss = s_in; clr = c; lap = l; rst = r;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, r, c, s_in, l);
    #1;
    ss = 1'b0; clr = 1'b0; lap = 1'b0; rst = 1'b1;
  endtask

  // Jump both instances to time t between clock edges (reaching 59:59 by counting is too slow).
  task automatic preload(input int t);
    pre_min = bcd2(t / 6000);
    pre_sec = bcd2((t / 100) % 60);
    pre_cs  = bcd2(t % 100);
    force u_dut0.min_q = pre_min; force u_dut0.sec_q = pre_sec; force u_dut0.cs_q = pre_cs;
    force u_dut1.min_q = pre_min; force u_dut1.sec_q = pre_sec; force u_dut1.cs_q = pre_cs;
    #1;
    release u_dut0.min_q; release u_dut0.sec_q; release u_dut0.cs_q;
    release u_dut1.min_q; release u_dut1.sec_q; release u_dut1.cs_q;
    m_t[0] = t;
    m_t[1] = t;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({min0, s0, ms0, min1, s1, ms1} !== 48'h0) begin
      fails++;
      $display("FAIL reset_time got=%h %h expected=all zero", {min0, s0, ms0}, {min1, s1, ms1});
    end
    tests++;
    if ({lapn0, run0, ovf0, lapn1, run1, ovf1} !== 6'b100100) begin
      fails++;
      $display("FAIL reset_flags got=%b expected=100100", {lapn0, run0, ovf0, lapn1, run1, ovf1});
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (got_vec(i) !== exp_vec(i)) begin
        fails++;
        $display("FAIL reset_model inst%0d got=%h expected=%h", i, got_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_count();
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (DIV) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (ms0 !== 8'h01 || run0 !== 1'b1) begin
      fails++;
      $display("FAIL first_tick got ms=%h running=%b expected ms=01 running=1", ms0, run0);
    end
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got_vec(i) !== exp_vec(i) || !digits_ok(i)) begin
          fails++;
          $display("FAIL count_model inst%0d got=%h expected=%h", i, got_vec(i), exp_vec(i));
        end
      end
    end
    tests++;
    if (ms0 !== 8'h11 || ms1 !== 8'h11) begin
      fails++;
      $display("FAIL count_11 got ms0=%h ms1=%h expected 11", ms0, ms1);
    end
  endtask

  task automatic test_carry();
    int budget;
    budget = 0;
    while (m_t[0] < 100 && budget < 2000) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      budget++;
      tests++;
      if (got_vec(0) !== exp_vec(0)) begin
        fails++;
        $display("FAIL carry_ms_model got=%h expected=%h", got_vec(0), exp_vec(0));
      end
    end
    tests++;
    if (ms0 !== 8'h00 || s0 !== 8'h01) begin
      fails++;
      $display("FAIL carry_ms got s=%h ms=%h expected s=01 ms=00", s0, ms0);
    end
    budget = 0;
    while (m_t[0] < 6000 && budget < 30000) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      budget++;
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got_vec(i) !== exp_vec(i) || !digits_ok(i)) begin
          fails++;
          $display("FAIL carry_s_model inst%0d got=%h expected=%h", i, got_vec(i), exp_vec(i));
        end
      end
    end
    tests++;
    if ({min0, s0, ms0} !== 24'h010000) begin
      fails++;
      $display("FAIL carry_min got=%h expected=010000", {min0, s0, ms0});
    end
  endtask

  task automatic test_pause();
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      tests++;
      if (ms0 !== 8'h00 || run0 !== 1'b0) begin
        fails++;
        $display("FAIL pause_frozen got ms=%h running=%b expected ms=00 running=0", ms0, run0);
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (ms0 !== 8'h00 || run0 !== 1'b1) begin
      fails++;
      $display("FAIL resume_early got ms=%h running=%b expected ms=00 running=1", ms0, run0);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (ms0 !== 8'h01) begin
      fails++;
      $display("FAIL resume_tick got ms=%h expected 01", ms0);
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (got_vec(i) !== exp_vec(i)) begin
        fails++;
        $display("FAIL pause_model inst%0d got=%h expected=%h", i, got_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_limit();
    int budget;
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    preload(LIMIT - 1);
    budget = 0;
    while (!m_ovf[1] && budget < 12) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      budget++;
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got_vec(i) !== exp_vec(i)) begin
          fails++;
          $display("FAIL limit_model inst%0d got=%h expected=%h", i, got_vec(i), exp_vec(i));
        end
      end
    end
    tests++;
    if (!m_ovf[1]) begin
      fails++;
      $display("FAIL limit_timeout got no limit tick within %0d cycles", budget);
    end
    tests++;
    if ({min0, s0, ms0, ovf0, run0} !== 26'h2_56_67_E6 >> 0 && {min0, s0, ms0, ovf0, run0} !== {24'h595999, 2'b10}) begin
      fails++;
      $display("FAIL sat_hold got=%h ovf=%b running=%b expected 595999 ovf=1 running=0", {min0, s0, ms0}, ovf0, run0);
    end
    tests++;
    if ({min1, s1, ms1, ovf1, run1} !== {24'h000000, 2'b11}) begin
      fails++;
      $display("FAIL wrap_zero got=%h ovf=%b running=%b expected 000000 ovf=1 running=1", {min1, s1, ms1}, ovf1, run1);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (ovf1 !== 1'b0 || run1 !== 1'b1 || ovf0 !== 1'b1) begin
      fails++;
      $display("FAIL ovf_width got ovf1=%b run1=%b ovf0=%b expected 0 1 1", ovf1, run1, ovf0);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    tests++;
    if ({min0, s0, ms0} !== 24'h595999 || run0 !== 1'b0 || ovf0 !== 1'b1) begin
      fails++;
      $display("FAIL full_ignores_ss got=%h running=%b ovf=%b expected 595999 0 1", {min0, s0, ms0}, run0, ovf0);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    tests++;
    if (lapn0 !== 1'b1 || lapn1 !== 1'b0) begin
      fails++;
      $display("FAIL lap_full_pause got lapn0=%b lapn1=%b expected 1 0", lapn0, lapn1);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    tests++;
    if ({min0, s0, ms0, min1, s1, ms1} !== 48'h0 || {ovf0, run0, ovf1, run1} !== 4'b0000) begin
      fails++;
      $display("FAIL limit_clear got=%h %h flags=%b expected zero 0000", {min0, s0, ms0}, {min1, s1, ms1}, {ovf0, run0, ovf1, run1});
    end
  endtask

  task automatic test_lap();
    int budget;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    preload(306);
    budget = 0;
    while (!(m_t[0] == 307 && m_acc[0] == DIV - 1) && budget < 20) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      budget++;
    end
    tests++;
    if (budget >= 20) begin
      fails++;
      $display("FAIL lap_setup_timeout got t=%0d expected 307 with tick due", m_t[0]);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    tests++;
    if (lapn0 !== 1'b0 || {s0, ms0} !== 16'h0307 || lapn1 !== 1'b0 || ms1 !== 8'h07) begin
      fails++;
      $display("FAIL lap_strobe got lapn=%b s.ms=%h expected lapn=0 0307", lapn0, {s0, ms0});
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (lapn0 !== 1'b1 || ms0 !== 8'h08) begin
      fails++;
      $display("FAIL lap_deferred got lapn=%b ms=%h expected lapn=1 ms=08", lapn0, ms0);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      tests++;
      if (lapn0 !== 1'b0) begin
        fails++;
        $display("FAIL lap_back_to_back cycle%0d got lapn=%b expected 0", k, lapn0);
      end
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got_vec(i) !== exp_vec(i)) begin
          fails++;
          $display("FAIL lap_model inst%0d got=%h expected=%h", i, got_vec(i), exp_vec(i));
        end
      end
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    tests++;
    if (lapn0 !== 1'b1 || {min0, s0, ms0} !== 24'h0) begin
      fails++;
      $display("FAIL lap_with_clr got lapn=%b time=%h expected lapn=1 000000", lapn0, {min0, s0, ms0});
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    tests++;
    if (lapn0 !== 1'b1 || lapn1 !== 1'b1) begin
      fails++;
      $display("FAIL lap_idle got lapn0=%b lapn1=%b expected 1 1", lapn0, lapn1);
    end
  endtask

  task automatic test_clr_ss();
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (run0 !== 1'b0 || {min0, s0, ms0} !== 24'h0) begin
      fails++;
      $display("FAIL clr_beats_ss got running=%b time=%h expected 0 000000", run0, {min0, s0, ms0});
    end
  endtask

  task automatic test_reset_midrun();
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (9) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({min0, s0, ms0, lapn0, run0, ovf0} !== {24'h0, 3'b100}) begin
      fails++;
      $display("FAIL reset_midrun got=%h expected=%h", {min0, s0, ms0, lapn0, run0, ovf0}, {24'h0, 3'b100});
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (DIV) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (ms0 !== 8'h01 || ms1 !== 8'h01) begin
      fails++;
      $display("FAIL reset_no_carry got ms0=%h ms1=%h expected 01", ms0, ms1);
    end
  endtask

  task automatic test_random();
    bit rs, rc, rl, rr;
    for (int k = 0; k < 4000; k++) begin
      rs = ($urandom_range(15) == 0);
      rc = ($urandom_range(63) == 0);
      rl = ($urandom_range(7) == 0);
      rr = ($urandom_range(499) != 0);
      if ((k % 500) == 250 &&
          (m_st[0] == M_RUN || m_st[0] == M_PAUSE) &&
          (m_st[1] == M_RUN || m_st[1] == M_PAUSE)) begin
        preload($urandom_range(LIMIT - 1, LIMIT - 30));
      end
      cycle(rs, rc, rl, rr);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got_vec(i) !== exp_vec(i) || !digits_ok(i)) begin
          fails++;
          $display("FAIL random_model inst%0d cycle%0d got=%h expected=%h", i, k, got_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; ss = 1'b0; clr = 1'b0; lap = 1'b0;
    test_reset();
    test_count();
    test_carry();
    test_pause();
    test_limit();
    test_lap();
    test_clr_ss();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
